seg_mux_driver: RTL and testbench

Parametrised, time-multiplexed hex driver for a common-anode seven-segment display with `DIGITS` positions. It holds a frame-synchronous snapshot of a `4*DIGITS`-bit value and scans one digit per refresh interval, driving active-low anodes and segments. It supports optional leading-zero blanking and per-digit decimal points. It sits between the RAT output-port register and the board display pins.

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_mux_if.sv | 27 ++
 rtl/hex7seg_decode.sv | 11 +
 rtl/seg_mux_driver.sv | 114 +++++++++++
 tb/tb_seg_mux_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and the hex-to-segment table for the seven-segment driver
package seg_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
  localparam seg_code_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_mux_if.sv
// rtl/seg_mux_if.sv - value/control inputs and display-pin outputs of the seven-segment driver
interface seg_mux_if #(
  parameter int DIGITS = 4
);
  import seg_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lzb_en;
  logic                  blank;
  seg_code_t             seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_start;

  modport master (
    output load, value, dp_in, lzb_en, blank,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  load, value, dp_in, lzb_en, blank,
    output seg, dp, an, frame_start
  );

endinterface

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational nibble to active-low segment pattern
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_code_t  seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed common-anode hex display driver with
// frame-synchronous snapshot, leading-zero blanking and per-digit decimal points
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_mux_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, snap_val_q;
  logic [DIGITS-1:0]     pend_dp_q, snap_dp_q;
  logic [DIGITS-1:0]     an_q, an_d;
  seg_code_t             seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q;

  logic                  tick;
  logic                  frame_tick;
  logic                  lz_blank;
  logic [3:0]            cur_nib;
  seg_code_t             dec_seg;

  assign tick       = (pcnt_q == PW'(REFRESH_DIV - 1));
  assign frame_tick = tick && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign cur_nib = snap_val_q[{idx_q, 2'b00} +: 4];

  hex7seg_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Digit idx is a leading zero when it and every more-significant nibble are zero
  always_comb begin
    lz_blank = 1'b0;
    if (bus.lzb_en && (idx_q != '0)) begin
      lz_blank = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if ((k >= int'(idx_q)) && (snap_val_q[4*k +: 4] != 4'h0)) begin
          lz_blank = 1'b0;
        end
      end
    end
  end

  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = dec_seg;
    dp_d  = ~snap_dp_q[idx_q];
    if (lz_blank) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
    if (bus.blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      // Snapshot reads pending before this cycle's load lands, so a coincident load waits a frame
      if (frame_tick) begin
        snap_val_q <= pend_val_q;
        snap_dp_q  <= pend_dp_q;
      end
      if (bus.load) begin
        pend_val_q <= bus.value;
        pend_dp_q  <= bus.dp_in;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= frame_tick;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - scoreboard bench for seg_mux_driver (4-digit scan model, 8-digit reset)
module tb_seg_mux_driver;

  localparam int RD = 4;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out4_t;

  logic clk = 1'b0;
  logic rst4_n = 1'b0;
  logic rst8_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_mux_if #(.DIGITS(4)) if4 ();
  seg_mux_if #(.DIGITS(8)) if8 ();

  seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(RD)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (if4.slave)
  );

  seg_mux_driver #(.DIGITS(8), .REFRESH_DIV(RD)) dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (if8.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic out4_t exp_out(int unsigned t, logic [15:0] snap, logic [3:0] sdp,
                                     logic lzb, logic blk);
    out4_t e;
    int    k;
    logic  lzz;
    k   = int'(((t - 1) / RD) % 4);
    lzz = lzb && (k >= 1) && ((snap >> (4 * k)) == 16'h0);
    e.an  = blk ? 4'hF : ~(4'b0001 << k);
    e.seg = (blk || lzz) ? 7'h7F : HEX[snap[4*k +: 4]];
    e.dp  = (blk || lzz) ? 1'b1 : ~sdp[k];
    e.fs  = ((t % (4 * RD)) == 0);
    return e;
  endfunction

  // Reference model: t counts edges since reset release; frame boundaries every 4*RD edges
  int unsigned  t_m;
  logic [15:0]  pend_m, snap_m;
  logic [3:0]   pdp_m, sdp_m;
  out4_t        exp_q[$];

  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) begin
      t_m    <= 0;
      pend_m <= '0;
      snap_m <= '0;
      pdp_m  <= '0;
      sdp_m  <= '0;
      exp_q.delete();
    end else begin
      exp_q.push_back(exp_out(t_m + 1, snap_m, sdp_m, if4.lzb_en, if4.blank));
      t_m <= t_m + 1;
      if (((t_m + 1) % (4 * RD)) == 0) begin
        snap_m <= pend_m;
        sdp_m  <= pdp_m;
      end
      if (if4.load) begin
        pend_m <= if4.value;
        pdp_m  <= if4.dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4_n) begin
      check_eq("rst4_out", 32'({if4.an, if4.seg, if4.dp, if4.frame_start}),
               32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end else if (exp_q.size() > 0) begin
      check_eq("scan4_out", 32'({if4.an, if4.seg, if4.dp, if4.frame_start}),
               32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    if4.load  = 1'b1;
    if4.value = v;
    if4.dp_in = d;
    @(negedge clk);
    if4.load  = 1'b0;
  endtask

  initial begin
    bit hit;
    if4.load = 1'b0; if4.value = '0; if4.dp_in = '0; if4.lzb_en = 1'b0; if4.blank = 1'b0;
    if8.load = 1'b0; if8.value = '0; if8.dp_in = '0; if8.lzb_en = 1'b0; if8.blank = 1'b0;
    cyc(3);
    rst4_n = 1'b1;
    rst8_n = 1'b1;

    // 8-digit instance: wait for digit 5 lit, then drop reset mid-cycle
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if8.an == 8'hDF) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("dig8_reach_idx5", 32'(hit), 32'd1);
    rst8_n = 1'b0;
    #1;
    check_eq("dig8_async_an", 32'(if8.an), 32'hFF);
    check_eq("dig8_async_seg", 32'(if8.seg), 32'h7F);
    check_eq("dig8_async_dp", 32'(if8.dp), 32'h1);
    cyc(2);
    rst8_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("dig8_restart_an", 32'(if8.an), 32'hFE);
    check_eq("dig8_restart_seg", 32'(if8.seg), 32'h40);

    // 4-digit: plain scan, mid-frame load, blanking, dp, blank, coincident load
    cyc(40);
    cyc(5);
    do_load(16'h1234, 4'b0000);
    cyc(40);
    if4.lzb_en = 1'b1;
    do_load(16'h0042, 4'b0000);
    cyc(40);
    do_load(16'h0000, 4'b0000);
    cyc(40);
    if4.lzb_en = 1'b0;
    do_load(16'hABCD, 4'b0100);
    cyc(36);
    if4.blank = 1'b1;
    cyc(6);
    if4.blank = 1'b0;
    cyc(10);

    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((t_m % (4 * RD)) == (4 * RD - 1)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("coincide_found", 32'(hit), 32'd1);
    if4.lzb_en = 1'b1;
    do_load(16'h5E70, 4'b1001);
    cyc(40);
    if4.lzb_en = 1'b0;
    cyc(3);
    check_eq("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
